// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/decode/execute controller for the 4-bit program counter.
// It fetches instruction bytes over a req/ack handshake and resolves
// NOP/JMP/JZ/JNZ/LOOP/HALT locally. Opcodes 0x5-0xE are handed to the
// execution unit over a start/done handshake.
//
// Ports
//   Clk, RST          clock; synchronous active-high reset
//   start             leave IDLE and begin fetching
//   pc_val[3:0]       current PC, used as the fetch address
//   mem_ack           mem_data is valid this cycle
//   mem_data[7:0]     instruction byte: [7:4] opcode, [3:0] operand
//   zero_flag         datapath zero flag, sampled during DECODE
//   exec_done         execution unit finished the current op
//   mem_req           fetch request (FETCH state)
//   mem_addr[3:0]     fetch address (= pc_val)
//   pc_wen, pc_bus    PC load strobe and load value (0 when not loading)
//   pc_rewind         PC restore-to-base strobe
//   pc_inc            PC increment strobe
//   exec_start        one-cycle start pulse to the execution unit
//   exec_op[3:0]      opcode for the execution unit, latched in DECODE
//   busy              high in every state except IDLE and HALT
//   halted            high in HALT
//   instr_cnt[7:0]    retired-instruction count, wraps modulo 256
module pc_sequencer (
    input  logic       Clk,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] pc_val,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    input  logic       zero_flag,
    input  logic       exec_done,
    output logic       mem_req,
    output logic [3:0] mem_addr,
    output logic       pc_wen,
    output logic [3:0] pc_bus,
    output logic       pc_rewind,
    output logic       pc_inc,
    output logic       exec_start,
    output logic [3:0] exec_op,
    output logic       busy,
    output logic       halted,
    output logic [7:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_STEP, S_HALT
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_ir;
    logic       r_zf;
    logic [3:0] r_exec_op;
    logic [7:0] r_instr_cnt;

    logic [3:0] w_opc;
    logic [3:0] w_operand;
    logic       w_dp_op;
    logic       w_retire;

    assign w_opc     = r_ir[7:4];
    assign w_operand = r_ir[3:0];
    assign w_dp_op   = (w_opc >= 4'h5) && (w_opc <= 4'hE);

    // Everything except datapath ops retires in EXEC (HALT retires on the
    // EXEC->HALT edge); datapath ops retire in STEP.
    assign w_retire  = ((r_state == S_EXEC) && !w_dp_op) || (r_state == S_STEP);

    always_ff @(posedge Clk) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_ir        <= 8'h00;
            r_zf        <= 1'b0;
            r_exec_op   <= 4'h0;
            r_instr_cnt <= 8'h00;
        end else begin
            if ((r_state == S_FETCH) && mem_ack) r_ir <= mem_data;
            if (r_state == S_DECODE) begin
                r_zf      <= zero_flag;
                r_exec_op <= r_ir[7:4];
            end
            if (w_retire) r_instr_cnt <= r_instr_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        pc_wen     = 1'b0;
        pc_bus     = 4'h0;
        pc_rewind  = 1'b0;
        pc_inc     = 1'b0;
        exec_start = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_opc)
                    4'h0: pc_inc = 1'b1;
                    4'h1: begin pc_wen = 1'b1; pc_bus = w_operand; end
                    4'h2: begin
                        if (r_zf) begin pc_wen = 1'b1; pc_bus = w_operand; end
                        else        pc_inc = 1'b1;
                    end
                    4'h3: begin
                        if (!r_zf) begin pc_wen = 1'b1; pc_bus = w_operand; end
                        else         pc_inc = 1'b1;
                    end
                    4'h4: pc_rewind = 1'b1;
                    4'hF: w_next = S_HALT;
                    default: begin
                        exec_start = 1'b1;
                        w_next     = S_WAIT;
                    end
                endcase
            end
            S_WAIT:   if (exec_done) w_next = S_STEP;
            S_STEP: begin
                pc_inc = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    assign mem_addr  = pc_val;
    assign exec_op   = r_exec_op;
    assign instr_cnt = r_instr_cnt;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);

endmodule
